// File: rtl/z88_kbd_scan.sv
// z88_kbd_scan: scans the 8x8 Z88 key matrix one row at a time and debounces
// every key and the flap switch. All scan, settle and debounce timing counts
// clk_ena ticks. The column and flap synchronisers run on every clk.
module z88_kbd_scan #(
  parameter int SETTLE_CYC     = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FLAP_DEBOUNCE  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_ena,
  input  logic        scan_en,
  output logic [7:0]  row_n,
  input  logic [7:0]  col_n,
  input  logic        flap_raw,
  output logic [63:0] kb_matrix,
  output logic        kb_any,
  output logic        flap_sw,
  output logic        frame_done,
  output logic [2:0]  state_dbg
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int KW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int FW = (FLAP_DEBOUNCE > 1) ? $clog2(FLAP_DEBOUNCE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [KW-1:0] KEY_LAST    = KW'(DEBOUNCE_SCANS - 1);
  localparam logic [FW-1:0] FLAP_LAST   = FW'(FLAP_DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    SAMPLE  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    row;
  logic [SW-1:0] settle_cnt;
  logic [KW-1:0] key_cnt [64];
  logic [FW-1:0] flap_cnt;
  logic [7:0]    col_meta, col_sync;
  logic          flap_meta, flap_sync;

  // Two-flop synchronisers; reset to the idle (released / open) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta  <= '1;
      col_sync  <= '1;
      flap_meta <= 1'b1;
      flap_sync <= 1'b1;
    end else begin
      col_meta  <= col_n;
      col_sync  <= col_meta;
      flap_meta <= flap_raw;
      flap_sync <= flap_meta;
    end
  end

  // State register: advances only on clk_ena ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_ena) begin
      state <= state_nxt;
    end
  end

  // Next-state logic: dropping scan_en forces IDLE from any state.
  always_comb begin
    state_nxt = state;
    if (!scan_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = DRIVE;
        DRIVE:   state_nxt = SETTLE;
        SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
        SAMPLE:  state_nxt = RELEASE;
        RELEASE: state_nxt = DRIVE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state: the row stays driven through DRIVE, SETTLE and SAMPLE.
  always_comb begin
    row_n = 8'hFF;
    if (state == DRIVE || state == SETTLE || state == SAMPLE) begin
      row_n[row] = 1'b0;
    end
    frame_done = clk_ena && scan_en && (state == SAMPLE) && (row == 3'd7);
    state_dbg  = state;
  end

  // Row index and settle counter; a stopped scan always restarts at row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      settle_cnt <= '0;
    end else if (clk_ena) begin
      if (!scan_en) begin
        row        <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          DRIVE:   settle_cnt <= '0;
          SETTLE:  settle_cnt <= settle_cnt + SW'(1);
          RELEASE: row        <= row + 3'd1;
          default: ;
        endcase
      end
    end
  end

  // Per-key debounce, evaluated for the current row's eight keys at SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_matrix <= '1;
      for (int i = 0; i < 64; i++) key_cnt[i] <= '0;
    end else if (clk_ena) begin
      if (!scan_en) begin
        for (int i = 0; i < 64; i++) key_cnt[i] <= '0;
      end else if (state == SAMPLE) begin
        for (int c = 0; c < 8; c++) begin
          if (col_sync[c] == kb_matrix[{row, 3'(c)}]) begin
            key_cnt[{row, 3'(c)}] <= '0;
          end else if (key_cnt[{row, 3'(c)}] == KEY_LAST) begin
            kb_matrix[{row, 3'(c)}] <= ~kb_matrix[{row, 3'(c)}];
            key_cnt[{row, 3'(c)}]   <= '0;
          end else begin
            key_cnt[{row, 3'(c)}] <= key_cnt[{row, 3'(c)}] + KW'(1);
          end
        end
      end
    end
  end

  // Any-key flag, registered one clk behind kb_matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_any <= 1'b0;
    end else begin
      kb_any <= ~&kb_matrix;
    end
  end

  // Flap debounce: independent of scan_en, counts disagreeing ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      flap_sw  <= 1'b0;
      flap_cnt <= '0;
    end else if (clk_ena) begin
      if (flap_sync == flap_sw) begin
        flap_cnt <= '0;
      end else if (flap_cnt == FLAP_LAST) begin
        flap_sw  <= ~flap_sw;
        flap_cnt <= '0;
      end else begin
        flap_cnt <= flap_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_z88_kbd_scan.sv
// Bench for z88_kbd_scan: directed steps with a physical key-matrix model
// driving col_n and an expected-value queue for the debounced matrix.
module tb_z88_kbd_scan;

  localparam logic [63:0] ALL_ONES = '1;
  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_SETTLE = 3'd2;
  localparam logic [2:0]  S_SAMPLE = 3'd3;

  logic        clk;
  logic        rst;
  logic        clk_ena;
  logic        scan_en;
  logic [7:0]  row_n;
  logic [7:0]  col_n;
  logic        flap_raw;
  logic [63:0] kb_matrix;
  logic        kb_any;
  logic        flap_sw;
  logic        frame_done;
  logic [2:0]  state_dbg;

  logic [63:0] keys;
  logic [63:0] exp_q[$];
  int          checks;
  int          errors;

  z88_kbd_scan dut (
    .clk        (clk),
    .rst        (rst),
    .clk_ena    (clk_ena),
    .scan_en    (scan_en),
    .row_n      (row_n),
    .col_n      (col_n),
    .flap_raw   (flap_raw),
    .kb_matrix  (kb_matrix),
    .kb_any     (kb_any),
    .flap_sw    (flap_sw),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Clock and reset-independent clk_ena strobe (about 3 ticks in 4 clks).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_ena = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      clk_ena = ($urandom_range(0, 3) != 0);
    end
  end

  // Physical switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 8'hFF;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (!row_n[r] && keys[r*8+c]) col_n[c] = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check(tag, {56'd0, obs}, {56'd0, exp});
  endtask

  // Advance to the next negedge whose following posedge is a clk_ena tick.
  task automatic next_tick();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (clk_ena) break;
    end
  endtask

  // Bounded wait for a negedge in state st with row r driven and clk_ena == ena.
  task automatic wait_at(input logic [2:0] st, input int r, input logic ena, input string tag);
    logic [7:0] pat;
    logic       found;
    pat   = ~(8'h01 << r);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (clk_ena == ena && state_dbg == st && row_n == pat) begin
        found = 1'b1;
        break;
      end
    end
    check1(tag, found, 1'b1);
  endtask

  // Wait for the next SAMPLE of row r, then compare kb_matrix just after it.
  task automatic sample_check(input int r, input string tag);
    wait_at(S_SAMPLE, r, 1'b1, {tag, "_wait"});
    @(posedge clk);
    #1;
    check(tag, kb_matrix, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] pat;
    int         n;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    scan_en  = 1'b0;
    flap_raw = 1'b0;
    keys     = '0;

    // Reset held for 3 clk while clk_ena toggles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("rst_row_n", row_n, 8'hFF);
    check("rst_kb_matrix", kb_matrix, ALL_ONES);
    check1("rst_kb_any", kb_any, 1'b0);
    check1("rst_flap_sw", flap_sw, 1'b0);
    check1("rst_frame_done", frame_done, 1'b0);
    check8("rst_state", {5'd0, state_dbg}, {5'd0, S_IDLE});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Row walk over two frames, no keys: 18 driven ticks then 1 released tick per row.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 8; r++) begin
        pat = ~(8'h01 << r);
        repeat (18) exp_q.push_back({56'd0, pat});
        exp_q.push_back({56'd0, 8'hFF});
      end
    scan_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_tick();
      if (row_n != 8'hFF) break;
    end
    n = 0;
    while (n < 304) begin
      if (clk_ena) begin
        check("row_walk", {56'd0, row_n}, exp_q.pop_front());
        check1("frame_done", frame_done, (n % 152) == 150);
        n++;
        if (n < 304) @(negedge clk);
      end else begin
        check1("frame_done_off_tick", frame_done, 1'b0);
        @(negedge clk);
      end
    end
    check("walk_kb_matrix", kb_matrix, ALL_ONES);

    // Press row 3 col 5: flips on the 4th row-3 sample, kb_any one clk later.
    keys[29] = 1'b1;
    repeat (3) exp_q.push_back(ALL_ONES);
    exp_q.push_back(~(64'h1 << 29));
    for (int i = 0; i < 4; i++) sample_check(3, "press_r3c5");
    check1("press_kb_any_lag", kb_any, 1'b0);
    @(posedge clk);
    #1;
    check1("press_kb_any", kb_any, 1'b1);

    // Release row 3 col 5: back to 1 after 4 further samples.
    keys[29] = 1'b0;
    repeat (3) exp_q.push_back(~(64'h1 << 29));
    exp_q.push_back(ALL_ONES);
    for (int i = 0; i < 4; i++) sample_check(3, "release_r3c5");
    check1("release_kb_any_lag", kb_any, 1'b1);
    @(posedge clk);
    #1;
    check1("release_kb_any", kb_any, 1'b0);

    // Bounce on row 0 col 0: 3 closed, 1 open, 3 closed gives no change; a 4th closed flips.
    keys[0] = 1'b1;
    repeat (3) exp_q.push_back(ALL_ONES);
    for (int i = 0; i < 3; i++) sample_check(0, "bounce_closed_a");
    keys[0] = 1'b0;
    exp_q.push_back(ALL_ONES);
    sample_check(0, "bounce_open");
    keys[0] = 1'b1;
    repeat (3) exp_q.push_back(ALL_ONES);
    exp_q.push_back(~64'h1);
    for (int i = 0; i < 4; i++) sample_check(0, "bounce_closed_b");
    keys[0] = 1'b0;
    repeat (3) exp_q.push_back(~64'h1);
    exp_q.push_back(ALL_ONES);
    for (int i = 0; i < 4; i++) sample_check(0, "bounce_release");

    // scan_en drop during row-5 SETTLE with row 5 col 1 two samples into its debounce.
    keys[41] = 1'b1;
    repeat (2) exp_q.push_back(ALL_ONES);
    for (int i = 0; i < 2; i++) sample_check(5, "mid_r5c1");
    wait_at(S_SETTLE, 5, 1'b1, "drop_wait");
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    check8("drop_row_n", row_n, 8'hFF);
    check8("drop_state", {5'd0, state_dbg}, {5'd0, S_IDLE});
    exp_q.push_back(ALL_ONES);
    check("drop_kb_matrix", kb_matrix, exp_q.pop_front());
    for (int i = 0; i < 40; i++) next_tick();
    check8("idle_row_n", row_n, 8'hFF);
    scan_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_tick();
      if (row_n != 8'hFF) break;
    end
    check8("restart_row", row_n, 8'hFE);
    repeat (3) exp_q.push_back(ALL_ONES);
    exp_q.push_back(~(64'h1 << 41));
    for (int i = 0; i < 4; i++) sample_check(5, "restart_r5c1");
    keys[41] = 1'b0;
    scan_en  = 1'b0;

    // Flap 0 -> 1: flips on the 1024th disagreeing tick after the sync delay.
    @(negedge clk);
    flap_raw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) next_tick();
    check1("flap_before_flip", flap_sw, 1'b0);
    @(posedge clk);
    #1;
    check1("flap_flip", flap_sw, 1'b1);

    // Two short glitches whose sum exceeds the threshold: agreement between them clears the count.
    @(negedge clk);
    flap_raw = 1'b0;
    for (int i = 0; i < 500; i++) next_tick();
    flap_raw = 1'b1;
    for (int i = 0; i < 20; i++) next_tick();
    check1("flap_glitch500", flap_sw, 1'b1);
    flap_raw = 1'b0;
    for (int i = 0; i < 600; i++) next_tick();
    flap_raw = 1'b1;
    for (int i = 0; i < 20; i++) next_tick();
    check1("flap_glitch600", flap_sw, 1'b1);

    // Reset mid-row on a clk without clk_ena releases the row on the next clk.
    scan_en = 1'b1;
    wait_at(S_SETTLE, 0, 1'b0, "midrst_wait");
    check8("midrst_row_driven", row_n, 8'hFE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("midrst_row_n", row_n, 8'hFF);
    check("midrst_kb_matrix", kb_matrix, ALL_ONES);
    check1("midrst_kb_any", kb_any, 1'b0);
    check1("midrst_flap_sw", flap_sw, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    scan_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
